// File: rtl/serial_assembler_pkg.sv
// Shared types and helpers for the serial-to-parallel assembler slice.
package serial_assembler_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } state_t;

  // Counter must represent 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/parallel_hold_slot.sv
// Single-entry valid/ready holding register with overrun detect.
// Latency: a load appears on the outputs on the loading edge's register update.
// Backpressure: a load while full and not draining is dropped and flags overrun.
module parallel_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             out_rdy,
  input  logic             overrun_clr,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic             overrun
);

  logic accept;
  logic drop;

  assign accept = out_vld & out_rdy;
  assign drop   = load_vld & out_vld & ~out_rdy;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      overrun <= 1'b0;
    end else begin
      // A load coinciding with a drain refills the slot with no bubble.
      if (load_vld && !drop) begin
        out_dat <= load_dat;
        out_vld <= 1'b1;
      end else if (accept) begin
        out_vld <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel_byte_assembler.sv
// Collects gated serial bits into DATA_WIDTH-bit words on a valid/ready output; PARITY_CHECK_EN adds an even-parity bit.
// Latency: word delivered on the edge sampling its last bit (parity bit when enabled).
// Backpressure: completion while the held word is unconsumed drops the new word and sets sticky Overrun_Out.
module serial_to_parallel_byte_assembler
  import serial_assembler_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int LSB_FIRST  = 1,
  localparam int CNT_W      = count_width(DATA_WIDTH)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Serial_Data_In,
  input  logic                  Serial_Valid_In,
  input  logic                  Frame_Start_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Parallel_Valid_Out,
  input  logic                  Parallel_Ready_In,
  output logic                  Overrun_Out,
  input  logic                  Overrun_Clear_In,
  output logic [CNT_W-1:0]      Bit_Count_Out
`ifdef PARITY_CHECK_EN
  ,
  output logic                  Parity_Error_Out
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int SLOT_W = DATA_WIDTH + 1;
`else
  localparam int SLOT_W = DATA_WIDTH;
`endif

  state_t                state, state_n, eff_state;
  logic [CNT_W-1:0]      cnt, cnt_n, eff_cnt, pos;
  logic [DATA_WIDTH-1:0] shreg, sh_n, base, word, load_word;
  logic                  load_vld;
  logic [SLOT_W-1:0]     slot_in, slot_out;
`ifdef PARITY_CHECK_EN
  logic                  perr_n;
`endif

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= sh_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = shreg;
    load_vld  = 1'b0;
    load_word = '0;
    word      = '0;
`ifdef PARITY_CHECK_EN
    perr_n    = 1'b0;
`endif
    // A frame start makes this edge behave as if the assembler were idle.
    eff_state = Frame_Start_In ? S_IDLE : state;
    eff_cnt   = Frame_Start_In ? '0 : cnt;
    base      = (eff_state == S_IDLE) ? '0 : shreg;
    pos       = (LSB_FIRST != 0) ? eff_cnt : (CNT_W'(DATA_WIDTH - 1) - eff_cnt);

    if (Frame_Start_In) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      sh_n    = '0;
    end

    if (Serial_Valid_In) begin
      case (eff_state)
        S_IDLE, S_SHIFT: begin
          word = base | (DATA_WIDTH'(Serial_Data_In) << pos);
          if (eff_cnt == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_n = S_PARITY;
            cnt_n   = CNT_W'(DATA_WIDTH);
            sh_n    = word;
`else
            load_vld  = 1'b1;
            load_word = word;
            state_n   = S_IDLE;
            cnt_n     = '0;
            sh_n      = '0;
`endif
          end else begin
            state_n = S_SHIFT;
            cnt_n   = eff_cnt + CNT_W'(1);
            sh_n    = word;
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          load_vld  = 1'b1;
          load_word = shreg;
          perr_n    = (^shreg) ^ Serial_Data_In;
          state_n   = S_IDLE;
          cnt_n     = '0;
          sh_n      = '0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  assign slot_in = {perr_n, load_word};
  assign {Parity_Error_Out, Parallel_Data_Out} = slot_out;
`else
  assign slot_in           = load_word;
  assign Parallel_Data_Out = slot_out;
`endif

  assign Bit_Count_Out = cnt;

  parallel_hold_slot #(
    .WIDTH(SLOT_W)
  ) u_hold (
    .Clk_In      (Clk_In),
    .Reset_In    (Reset_In),
    .load_vld    (load_vld),
    .load_dat    (slot_in),
    .out_rdy     (Parallel_Ready_In),
    .overrun_clr (Overrun_Clear_In),
    .out_vld     (Parallel_Valid_Out),
    .out_dat     (slot_out),
    .overrun     (Overrun_Out)
  );

endmodule

// File: tb/tb_serial_to_parallel_byte_assembler.sv
// Directed bench for serial_to_parallel_byte_assembler, LSB-first and MSB-first instances in parallel.
module tb_serial_to_parallel_byte_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sd  = 1'b0;
  logic       sv  = 1'b0;
  logic       fs  = 1'b0;
  logic       rdy = 1'b0;
  logic       oc  = 1'b0;

  logic [7:0] pd_l, pd_m;
  logic       pv_l, pv_m, ov_l, ov_m;
  logic [3:0] bc_l, bc_m;
`ifdef PARITY_CHECK_EN
  logic       pe_l, pe_m;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q_l[$];
  logic [7:0] q_m[$];

  always #5 clk = ~clk;

  serial_to_parallel_byte_assembler #(.DATA_WIDTH(8), .LSB_FIRST(1)) dut (
    .Clk_In(clk), .Reset_In(rst), .Serial_Data_In(sd), .Serial_Valid_In(sv),
    .Frame_Start_In(fs), .Parallel_Data_Out(pd_l), .Parallel_Valid_Out(pv_l),
    .Parallel_Ready_In(rdy), .Overrun_Out(ov_l), .Overrun_Clear_In(oc),
    .Bit_Count_Out(bc_l)
`ifdef PARITY_CHECK_EN
    , .Parity_Error_Out(pe_l)
`endif
  );

  serial_to_parallel_byte_assembler #(.DATA_WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .Clk_In(clk), .Reset_In(rst), .Serial_Data_In(sd), .Serial_Valid_In(sv),
    .Frame_Start_In(fs), .Parallel_Data_Out(pd_m), .Parallel_Valid_Out(pv_m),
    .Parallel_Ready_In(rdy), .Overrun_Out(ov_m), .Overrun_Clear_In(oc),
    .Bit_Count_Out(bc_m)
`ifdef PARITY_CHECK_EN
    , .Parity_Error_Out(pe_m)
`endif
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sd = b;
    sv = 1'b1;
    tick();
    sv = 1'b0;
    sd = 1'b0;
  endtask

  // Everything except the delivering bit (data bit 7, or the parity bit).
  task automatic send_prefix(input logic [7:0] w);
    for (int i = 0; i < 7; i++) send_bit(w[i]);
`ifdef PARITY_CHECK_EN
    send_bit(w[7]);
`endif
  endtask

  task automatic send_last(input logic [7:0] w);
`ifdef PARITY_CHECK_EN
    send_bit(^w);
`else
    send_bit(w[7]);
`endif
  endtask

  task automatic send_word(input logic [7:0] w);
    send_prefix(w);
    send_last(w);
  endtask

  task automatic expect_word(input logic [7:0] w);
    q_l.push_back(w);
    q_m.push_back(rev8(w));
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] el, em;
    check({tag, "_vld"}, 32'(pv_l & pv_m), 32'd1);
    if (q_l.size() == 0 || q_m.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=output expected=no pending scoreboard entry", tag);
    end else begin
      el = q_l.pop_front();
      em = q_m.pop_front();
      check({tag, "_lsb"}, 32'(pd_l), 32'(el));
      check({tag, "_msb"}, 32'(pd_m), 32'(em));
    end
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_data", 32'(pd_l), 32'h0);
    check("rst_vld", 32'(pv_l), 32'h0);
    check("rst_ovr", 32'(ov_l), 32'h0);
    check("rst_cnt", 32'(bc_l), 32'h0);
    rst = 1'b0;
    tick();

    // 0xA5 LSB-first bit stream, consumer always ready
    rdy = 1'b1;
    expect_word(8'hA5);
    for (int i = 0; i < 7; i++) send_bit(8'hA5 >> i);
    check("a5_cnt7", 32'(bc_l), 32'd7);
`ifdef PARITY_CHECK_EN
    send_bit(1'b1);
`endif
    send_last(8'hA5);
    check_pop("a5");
    tick();
    check("a5_drain", 32'(pv_l), 32'd0);

    // 1,1,0,0,0,0,0,0 -> 0x03 LSB-first, 0xC0 MSB-first
    expect_word(8'h03);
    send_word(8'h03);
    check_pop("w03");
    tick();
    check("w03_drain", 32'(pv_m), 32'd0);

    // Overrun: hold 0x3C, drop 0xC3
    rdy = 1'b0;
    expect_word(8'h3C);
    send_word(8'h3C);
    check("hold_vld", 32'(pv_l), 32'd1);
    send_word(8'hC3);
    check_pop("ovr_hold");
    check("ovr_set", 32'(ov_l & ov_m), 32'd1);
    rdy = 1'b1;
    tick();
    check("ovr_drain", 32'(pv_l), 32'd0);
    check("ovr_sticky", 32'(ov_l), 32'd1);
    oc = 1'b1;
    tick();
    oc = 1'b0;
    check("ovr_clear", 32'(ov_l | ov_m), 32'd0);

    // Ready arrives exactly on the completing edge of the next word
    rdy = 1'b0;
    send_word(8'h3C);
    send_prefix(8'h5A);
    check("pre_accept", 32'(pd_l), 32'h3C);
    rdy = 1'b1;
    expect_word(8'h5A);
    send_last(8'h5A);
    check_pop("back2back");
    check("b2b_no_ovr", 32'(ov_l), 32'd0);
    tick();
    check("b2b_drain", 32'(pv_l), 32'd0);

    // Frame restart after five bits
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("fs_cnt5", 32'(bc_l), 32'd5);
    fs = 1'b1;
    send_bit(1'b1);
    fs = 1'b0;
    check("fs_cnt1", 32'(bc_l), 32'd1);
    check("fs_cnt1_msb", 32'(bc_m), 32'd1);
    expect_word(8'hFF);
    for (int i = 1; i < 8; i++) send_bit(1'b1);
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    check_pop("fs_ff");
    tick();

    // Async reset while a word is held and a partial word is in progress
    rdy = 1'b0;
    send_word(8'h11);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("pre_rst_cnt", 32'(bc_l), 32'd4);
    rst = 1'b1;
    #1;
    check("arst_data", 32'(pd_l | pd_m), 32'h0);
    check("arst_vld", 32'(pv_l | pv_m), 32'h0);
    check("arst_cnt", 32'(bc_l | bc_m), 32'h0);
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    expect_word(8'h80);
    send_word(8'h80);
    check_pop("post_rst");
    check("post_rst_cnt", 32'(bc_l), 32'd0);
    tick();

`ifdef PARITY_CHECK_EN
    // Even parity: 0xA5 has four ones, so a parity bit of 1 is an error
    for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
    send_bit(1'b1);
    check("perr_set", 32'(pe_l), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
    send_bit(1'b0);
    check("perr_clr", 32'(pe_l), 32'd0);
    check("perr_vld", 32'(pv_l), 32'd1);
    tick();
`endif

    check("sb_empty", 32'(q_l.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_byte_assembler.md
Name: serial_to_parallel_byte_assembler

Overview:
Upstream feeder for the team's 8-bit parallel-in-parallel-out register stage. It collects a gated serial bit stream into DATA_WIDTH-bit words and holds each completed word on a valid/ready parallel output. It flags words lost to backpressure. Outputs are registered on the rising edge of Clk_In, so the downstream falling-edge stage samples stable data half a cycle later.

Parameters:
DATA_WIDTH, 8, bits per assembled word (legal range 2..32)
LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit DATA_WIDTH-1

Ports:
Clk_In  input  1  clock; all state updates on the rising edge
Reset_In  input  1  reset, asynchronous, active-high
Serial_Data_In  input  1  serial data bit
Serial_Valid_In  input  1  Serial_Data_In is sampled on this edge
Frame_Start_In  input  1  synchronous; aborts any partial word, restarts bit count
Parallel_Data_Out  output  DATA_WIDTH  assembled word
Parallel_Valid_Out  output  1  Parallel_Data_Out holds an unconsumed word
Parallel_Ready_In  input  1  consumer accepts the word on this edge
Overrun_Out  output  1  sticky; a completed word was dropped
Overrun_Clear_In  input  1  synchronous clear of Overrun_Out
Bit_Count_Out  output  $clog2(DATA_WIDTH+1)  bits collected in the current partial word

Behaviour:
- Reset (async, Reset_In=1):
  - Parallel_Data_Out=0, Parallel_Valid_Out=0, Overrun_Out=0, Bit_Count_Out=0.
  - Shift register cleared; FSM goes to S_IDLE.
  - A partial word in progress is discarded.
- FSM states:
  - S_IDLE: count=0. A sampled bit moves to S_SHIFT.
  - S_SHIFT: 1..DATA_WIDTH-1 bits held. The DATA_WIDTH-th bit moves to S_IDLE, or to S_PARITY when the parity feature is enabled.
  - S_PARITY: exists only when the parity feature is enabled. A sampled bit moves to S_IDLE.
- Bit sampling: a bit is sampled only on an edge with Serial_Valid_In=1. The k-th bit (k=0..DATA_WIDTH-1) goes to bit k if LSB_FIRST=1, else to bit DATA_WIDTH-1-k.
- Word completion: the word is delivered on the same edge that samples its last bit. Parallel_Data_Out and Parallel_Valid_Out update on that edge, giving zero added cycles of latency.
- Handshake: transfer occurs on an edge with Parallel_Valid_Out=1 and Parallel_Ready_In=1. While Parallel_Valid_Out=1 and no transfer occurs, Parallel_Data_Out must not change.
- Simultaneous transfer and completion: the new word loads and Parallel_Valid_Out stays 1 with no bubble.
- Completion while full (valid=1, ready=0): the new word is dropped. Overrun_Out is set, and the held word is unchanged.
- Overrun clear: Overrun_Out clears only on reset or Overrun_Clear_In=1. If a drop and a clear happen on the same edge, set wins.
- Frame_Start_In=1: the count goes to 0 and the partial word is discarded. If Serial_Valid_In=1 on the same edge, that bit becomes bit 0 of a new word. The holding slot and Overrun_Out are unaffected.
- Parallel_Ready_In is ignored while Parallel_Valid_Out=0.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - One extra serial bit follows the data bits; it is an even-parity bit over the word.
  - The word is delivered on the parity bit's edge.
  - Added output Parity_Error_Out (1 bit) is registered alongside the word and is valid while Parallel_Valid_Out=1. It is 1 if the XOR of the data and parity bits is 1.
  - A word with a parity error is still delivered.
  - Frame_Start_In during S_PARITY aborts the word.
  - Parity_Error_Out resets to 0.
- Undefined: there is no S_PARITY state and no Parity_Error_Out port. Delivery happens on the DATA_WIDTH-th bit.

Decomposition:
- Package serial_assembler_pkg holds:
  - state enum (S_IDLE, S_SHIFT, S_PARITY)
  - DEFAULT_DATA_WIDTH=8
  - count-width helper function
- One natural sub-module: parallel_hold_slot. It is a single-entry valid/ready register with load, accept and overrun detect. It is reusable ahead of other falling-edge stages.

Test Plan:
- LSB_FIRST=1, ready=1, bits 1,0,1,0,0,1,0,1 on consecutive edges -> Parallel_Data_Out=0xA5 and valid=1 after the 8th edge; valid=0 one edge later.
- LSB_FIRST=0, same bit sequence -> Parallel_Data_Out=0xA5 byte-reversed = 0xA5 mirrored (0xA5); then repeat with 1,1,0,0,0,0,0,0 -> 0xC0 (LSB_FIRST=1 gives 0x03).
- ready=0, send 0x3C then 0xC3 -> data stays 0x3C, valid=1, Overrun_Out=1 after 0xC3 completes. Then ready=1 for one edge -> valid=0. Overrun_Clear_In pulse -> Overrun_Out=0.
- ready=1 asserted exactly on the completing edge of the second word 0x5A while 0x3C is held -> 0x3C accepted, 0x5A loaded, valid continuous, Overrun_Out=0.
- Five bits sent, Frame_Start_In with Serial_Valid_In=1 bit=1, then bits 1x7 -> 0xFF delivered. Bit_Count_Out shows 5 -> 1 on the restart edge.
- Reset_In pulsed after 4 bits while 0x11 is held -> all outputs 0 immediately. A following 8-bit 0x80 delivers 0x80 cleanly. With PARITY_CHECK_EN, 0xA5 + parity 1 -> Parity_Error_Out=1; with parity 0 -> 0.
